switch_conditioner: RTL and testbench

//   Front end for the 16 UI slide switches. Synchronises raw pad levels into clk_in,

---
 rtl/switch_conditioner.sv | 81 ++++++++
 tb/tb_switch_conditioner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Slide-switch front end: per-bit synchroniser and debouncer, plus a registered
// one-cycle change strobe with a mask of the bits that moved.
module switch_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw,
  output logic level,
  output logic update
);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  // Combinational so the top can register the strobe on the same edge as level.
  assign update   = (sync_bit != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Any return to the accepted level throws away partial progress.
      if (sync_bit == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_bit;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module switch_conditioner #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] sw_raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed_out,
  output logic [WIDTH-1:0] changed_mask_out
);
  logic [WIDTH-1:0] update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .raw     (sw_raw_in[i]),
      .level   (sw_out[i]),
      .update  (update[i])
    );
  end

  // Bits finishing together collapse into a single strobe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sw_changed_out   <= 1'b0;
      changed_mask_out <= '0;
    end else begin
      sw_changed_out   <= |update;
      changed_mask_out <= update;
    end
  end
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
module tb_switch_conditioner;
  localparam int W = 16;

  logic          clk_in;
  logic          rst_n_in;
  logic [W-1:0]  sw_raw_in;
  logic [W-1:0]  sw_out;
  logic          sw_changed_out;
  logic [W-1:0]  changed_mask_out;

  int errors = 0;
  int checks = 0;

  switch_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .sw_raw_in       (sw_raw_in),
    .sw_out          (sw_out),
    .sw_changed_out  (sw_changed_out),
    .changed_mask_out(changed_mask_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Runs exactly n edges; reports first pulse edge (-1 if none), its mask, pulse count.
  task automatic run_edges(input int n, output int first_edge,
                           output logic [W-1:0] first_mask, output int pulses);
    first_edge = -1;
    first_mask = '0;
    pulses     = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (sw_changed_out) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = k;
          first_mask = changed_mask_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    int e, p;
    logic [W-1:0] m;
    sw_raw_in = '0;
    rst_n_in  = 1'b0;
    #12;
    checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL reset_sw_out got=%h exp=0000", sw_out); end
    checks++; if (sw_changed_out !== 1'b0) begin errors++; $display("FAIL reset_changed got=%b exp=0", sw_changed_out); end
    checks++; if (changed_mask_out !== 16'h0000) begin errors++; $display("FAIL reset_mask got=%h exp=0000", changed_mask_out); end
    tick();
    rst_n_in = 1'b1;
    run_edges(50, e, m, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL idle_pulses got=%0d exp=0", p); end
    checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL idle_sw_out got=%h exp=0000", sw_out); end
  endtask

  task automatic test_single_rise();
    int e, p;
    logic [W-1:0] m;
    sw_raw_in = 16'h0001;
    run_edges(20, e, m, p);
    checks++; if (e !== 10) begin errors++; $display("FAIL single_latency got=%0d exp=10", e); end
    checks++; if (m !== 16'h0001) begin errors++; $display("FAIL single_mask got=%h exp=0001", m); end
    checks++; if (p !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", p); end
    checks++; if (sw_out !== 16'h0001) begin errors++; $display("FAIL single_sw_out got=%h exp=0001", sw_out); end
  endtask

  task automatic test_glitch();
    int e, p;
    logic [W-1:0] m;
    sw_raw_in = 16'h0009;
    repeat (5) tick();
    sw_raw_in = 16'h0001;
    run_edges(20, e, m, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", p); end
    checks++; if (sw_out !== 16'h0001) begin errors++; $display("FAIL glitch_sw_out got=%h exp=0001", sw_out); end
    sw_raw_in = 16'h0009;
    run_edges(10, e, m, p);
    checks++; if (e !== 10 || m !== 16'h0008) begin errors++; $display("FAIL accept_bit3 edge=%0d mask=%h exp edge=10 mask=0008", e, m); end
    checks++; if (sw_out !== 16'h0009) begin errors++; $display("FAIL accept_sw_out got=%h exp=0009", sw_out); end
    sw_raw_in = 16'h0001;
    run_edges(20, e, m, p);
    checks++; if (e !== 10 || m !== 16'h0008 || p !== 1) begin errors++; $display("FAIL release_bit3 edge=%0d mask=%h pulses=%0d exp 10/0008/1", e, m, p); end
    checks++; if (sw_out !== 16'h0001) begin errors++; $display("FAIL release_sw_out got=%h exp=0001", sw_out); end
  endtask

  task automatic test_simultaneous();
    int e, p;
    logic [W-1:0] m;
    sw_raw_in = 16'h0000;
    run_edges(20, e, m, p);
    checks++; if (sw_out !== 16'h0000 || m !== 16'h0001) begin errors++; $display("FAIL clear_bit0 sw=%h mask=%h exp 0000/0001", sw_out, m); end
    sw_raw_in = 16'h8001;
    run_edges(20, e, m, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL simul_pulses got=%0d exp=1", p); end
    checks++; if (e !== 10 || m !== 16'h8001) begin errors++; $display("FAIL simul_mask edge=%0d mask=%h exp 10/8001", e, m); end
    checks++; if (sw_out !== 16'h8001) begin errors++; $display("FAIL simul_sw_out got=%h exp=8001", sw_out); end
  endtask

  task automatic test_bounce();
    int e, p;
    logic [W-1:0] m;
    for (int c = 0; c < 30; c++) begin
      sw_raw_in = ((c / 3) % 2 == 0) ? 16'h8021 : 16'h8001;
      tick();
      checks++; if (sw_changed_out !== 1'b0) begin errors++; $display("FAIL bounce_pulse cycle=%0d got=1 exp=0", c); end
    end
    sw_raw_in = 16'h8021;
    run_edges(20, e, m, p);
    checks++; if (p !== 1 || e !== 10 || m !== 16'h0020) begin errors++; $display("FAIL bounce_settle pulses=%0d edge=%0d mask=%h exp 1/10/0020", p, e, m); end
    checks++; if (sw_out !== 16'h8021) begin errors++; $display("FAIL bounce_sw_out got=%h exp=8021", sw_out); end
  endtask

  task automatic test_reset_mid_count();
    int e, p;
    logic [W-1:0] m;
    sw_raw_in = 16'hFFFF;
    repeat (7) tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL async_reset_sw_out got=%h exp=0000", sw_out); end
    checks++; if (sw_changed_out !== 1'b0 || changed_mask_out !== 16'h0000) begin errors++; $display("FAIL async_reset_strobe chg=%b mask=%h exp 0/0000", sw_changed_out, changed_mask_out); end
    repeat (3) tick();
    rst_n_in = 1'b1;
    run_edges(20, e, m, p);
    checks++; if (e !== 10 || m !== 16'hFFFF || p !== 1) begin errors++; $display("FAIL post_reset edge=%0d mask=%h pulses=%0d exp 10/FFFF/1", e, m, p); end
    checks++; if (sw_out !== 16'hFFFF) begin errors++; $display("FAIL post_reset_sw_out got=%h exp=FFFF", sw_out); end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_bounce();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
